// File: rtl/spart_tx_if.sv
// spart_tx_if: core-side SPART transmit bus (write strobe, byte, address, backpressure, line status)
interface spart_tx_if;
  logic       send;
  logic [7:0] send_data;
  logic [2:0] spart_addr;
  logic       full;
  logic       txd;
  logic       tx_busy;
  modport master (output send, send_data, spart_addr, input full, txd, tx_busy);
  modport slave  (input send, send_data, spart_addr, output full, txd, tx_busy);
endinterface

// File: rtl/spart_tx.sv
// spart_tx: FIFO-buffered async serial transmitter with programmable baud divisor
// SPART_TX_PARITY_EN adds an even-parity bit between data and stop
module spart_tx #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input logic       clk,
  input logic       rst,
  spart_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        st, st_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count, count_n;
  logic [15:0]   div, bcnt;
  logic [7:0]    sh, sh_n, head;
  logic [2:0]    idx;
  logic          full, txd, tx_busy, push, pop, tick, txd_n;
`ifdef SPART_TX_PARITY_EN
  logic          par;
`endif
  assign head    = mem[rp];
  assign push    = bus.send && bus.spart_addr == 3'b000 && !full;
  assign pop     = st == IDLE && count != '0;
  assign tick    = bcnt == '0;
  assign count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign sh_n    = pop ? head : (st == DATA && tick) ? sh >> 1 : sh;
  assign bus.full    = full;
  assign bus.txd     = txd;
  assign bus.tx_busy = tx_busy;
  always_comb begin
    st_n = st;
    case (st)
      IDLE:   st_n = pop ? START : IDLE;
      START:  st_n = tick ? DATA : START;
`ifdef SPART_TX_PARITY_EN
      DATA:   st_n = (tick && idx == 3'd7) ? PARITY : DATA;
      PARITY: st_n = tick ? STOP : PARITY;
`else
      DATA:   st_n = (tick && idx == 3'd7) ? STOP : DATA;
`endif
      STOP:   st_n = tick ? IDLE : STOP;
      default: st_n = IDLE;
    endcase
  end
  // txd is registered from the next state so the line changes exactly on bit boundaries
`ifdef SPART_TX_PARITY_EN
  assign txd_n = st_n == START ? 1'b0 : st_n == DATA ? sh_n[0] : st_n == PARITY ? par : 1'b1;
`else
  assign txd_n = st_n == START ? 1'b0 : st_n == DATA ? sh_n[0] : 1'b1;
`endif
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus.send_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      full    <= 1'b0;
      div     <= DIV_RESET;
      bcnt    <= '0;
      st      <= IDLE;
      sh      <= '0;
      idx     <= '0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
`ifdef SPART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      if (bus.send && bus.spart_addr == 3'b100) div[7:0]  <= bus.send_data;
      if (bus.send && bus.spart_addr == 3'b101) div[15:8] <= bus.send_data;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count   <= count_n;
      full    <= count_n == (AW+1)'(DEPTH);
      // divisor is sampled only at reload, so a write never stretches or cuts the current bit
      bcnt    <= (pop || tick) ? div : bcnt - 1'b1;
      st      <= st_n;
      sh      <= sh_n;
      idx     <= st == DATA ? idx + {2'b00, tick} : 3'd0;
      txd     <= txd_n;
      tx_busy <= st_n != IDLE || count_n != '0;
`ifdef SPART_TX_PARITY_EN
      if (pop) par <= ^head;
`endif
    end
  end
endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: scoreboarded bench; a line monitor decodes txd frames and checks them against queued bytes
module tb_spart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spart_tx_if bus();
  spart_tx #(.DEPTH(4), .DIV_RESET(16'd433)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef SPART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int cur_p = 434;
  bit mon_en = 1'b1;
  bit mon_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // reference frame: start 0, data LSB first, optional even parity, stop 1
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef SPART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && bus.txd === 1'b0) begin
        logic [7:0]  b;
        logic [10:0] fb;
        int          bad;
        logic        got;
        mon_busy = 1'b1;
        bad = -1;
        got = 1'b0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: frame started with no byte queued");
          repeat (NB * cur_p - 1) @(negedge clk);
        end else begin
          b  = exp_q.pop_front();
          fb = frame_bits(b);
          for (int i = 0; i < NB * cur_p; i++) begin
            if (bad < 0 && bus.txd !== fb[i / cur_p]) begin
              bad = i;
              got = bus.txd;
            end
            if (i < NB * cur_p - 1) @(negedge clk);
          end
          n_tests++;
          if (bad >= 0) begin
            n_fail++;
            $display("FAIL frame_%02h: clk %0d of frame txd=%b expected %b", b, bad, got, fb[bad / cur_p]);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.send = 1'b1;
    bus.spart_addr = a;
    bus.send_data = d;
    if (a == 3'b000 && !bus.full && mon_en) exp_q.push_back(d);
    @(posedge clk);
    #1 bus.send = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.tx_busy || mon_busy || exp_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", t < 20000, 1);
    @(negedge clk);
  endtask

  task automatic set_div(input logic [15:0] v);
    wait_idle();
    wr(3'b100, v[7:0]);
    wr(3'b101, v[15:8]);
    cur_p = int'(v) + 1;
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.send = 1'b0;
    bus.spart_addr = 3'b000;
    bus.send_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", bus.txd, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_busy", bus.tx_busy, 0);
    @(negedge clk) rst = 1'b0;
    wr(3'b000, 8'hA5);
    wait_idle();
    set_div(16'd3);
    wr(3'b000, 8'h55);
    chk("lat_pre_txd", bus.txd, 1);
    chk("busy_on_write", bus.tx_busy, 1);
    @(posedge clk);
    #1 chk("lat_txd_fall", bus.txd, 0);
    repeat (39) @(posedge clk);
    #1 chk("busy_in_stop", bus.tx_busy, 1);
    repeat (2) @(posedge clk);
    #1 chk("busy_done", bus.tx_busy, 0);
    wait_idle();
    for (int i = 1; i <= 5; i++) begin
      wr(3'b000, 8'(i));
      chk($sformatf("burst_full_%0d", i), bus.full, i == 5);
    end
    wr(3'b000, 8'h06);
    begin
      int t = 0;
      @(negedge clk);
      while (bus.full && t < 500) begin
        bus.send = 1'b1;
        bus.spart_addr = 3'b000;
        bus.send_data = 8'hEE;
        @(negedge clk);
        t++;
      end
      bus.send = 1'b0;
      chk("full_release", t < 500, 1);
    end
    wr(3'b000, 8'h77);
    chk("full_at_depth_minus1_plus1", bus.full, 1);
    wait_idle();
    set_div(16'd0);
    wr(3'b000, 8'h07);
    wr(3'b000, 8'h03);
    wr(3'b000, 8'h00);
    wr(3'b000, 8'hFF);
    wait_idle();
    set_div(16'h0102);
    wr(3'b000, 8'h3C);
    wait_idle();
    for (int r = 0; r < 4; r++) begin
      set_div(16'($urandom_range(0, 5)));
      for (int k = 0; k < 12; k++) begin
        wr(3'b000, 8'($urandom));
        repeat ($urandom_range(0, cur_p * NB * 2)) @(posedge clk);
      end
      wait_idle();
    end
    set_div(16'd3);
    mon_en = 1'b0;
    wr(3'b000, 8'h55);
    begin
      int t = 0;
      logic [39:0] tr, ex;
      logic [10:0] fb;
      int k, acc;
      do begin
        @(negedge clk);
        t++;
      end while (bus.txd && t < 50);
      chk("divchg_start", t < 50, 1);
      for (int i = 0; i < 40; i++) begin
        tr[i] = bus.txd;
        if (i == 13) begin
          bus.send = 1'b1;
          bus.spart_addr = 3'b100;
          bus.send_data = 8'd7;
        end
        if (i == 14) bus.send = 1'b0;
        if (i < 39) @(negedge clk);
      end
      fb = frame_bits(8'h55);
      k = 0;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
        if (i - acc >= (k < 4 ? 4 : 8)) begin
          acc += (k < 4 ? 4 : 8);
          k++;
        end
        ex[i] = fb[k];
      end
      chk("div_change", tr, ex);
    end
    wait_idle();
    set_div(16'd3);
    wr(3'b000, 8'hF0);
    wr(3'b000, 8'h11);
    wr(3'b000, 8'h22);
    repeat (20) @(posedge clk);
    #1 chk("busy_before_rst", bus.tx_busy, 1);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_txd", bus.txd, 1);
    chk("midrst_full", bus.full, 0);
    chk("midrst_busy", bus.tx_busy, 0);
    #20;
    @(negedge clk) rst = 1'b0;
    mon_en = 1'b1;
    begin
      logic seen_low = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0) seen_low = 1'b1;
      end
      chk("no_frame_after_rst", seen_low, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
